// File: rtl/down_counter_timer.sv
// Loadable down counter with one-cycle terminal-count pulse and optional
// periodic auto-reload from the last loaded value.
module down_counter_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] counter,
    output logic             tc,
    output logic             busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]       state_q,   state_d;
    logic [WIDTH-1:0] counter_q, counter_d;
    logic [WIDTH-1:0] reload_q,  reload_d;
    logic             tc_q,      tc_d;
    logic             busy_q,    busy_d;

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        reload_d  = reload_q;
        tc_d      = 1'b0;

        if (load) begin
            // A load pre-empts everything, including a coincident terminal event.
            counter_d = load_val;
            reload_d  = load_val;
            state_d   = (load_val != ZERO) ? S_RUN : S_IDLE;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (en) begin
                        if (counter_q > ONE) begin
                            counter_d = counter_q - ONE;
                        end else if (counter_q == ONE) begin
                            tc_d = 1'b1;
                            if (auto_reload) begin
                                counter_d = reload_q;
                            end else begin
                                counter_d = ZERO;
                                state_d   = S_DONE;
                            end
                        end
                    end
                end
                S_IDLE, S_DONE: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            counter_q <= ZERO;
            reload_q  <= ZERO;
            tc_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            reload_q  <= reload_d;
            tc_q      <= tc_d;
            busy_q    <= busy_d;
        end
    end

    assign counter = counter_q;
    assign tc      = tc_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed bench for down_counter_timer: stimulus pushes hand-computed
// expectations into a scoreboard queue that a monitor drains after each edge.
module tb_down_counter_timer;

    logic       clk;
    logic       rst;
    logic       load;
    logic [3:0] load_val;
    logic       en;
    logic       auto_reload;
    logic [3:0] counter;
    logic       tc;
    logic       busy;

    typedef struct {
        logic [3:0] cnt;
        logic       tc;
        logic       busy;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    down_counter_timer #(.WIDTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .load(load),
        .load_val(load_val),
        .en(en),
        .auto_reload(auto_reload),
        .counter(counter),
        .tc(tc),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle: drive inputs, record what must be seen after the next edge.
    task automatic step(input logic r, input logic ld, input logic [3:0] lv,
                        input logic e, input logic ar,
                        input logic [3:0] ec, input logic et, input logic eb,
                        input string nm);
        exp_t x;
        @(negedge clk);
        rst = r; load = ld; load_val = lv; en = e; auto_reload = ar;
        x.cnt = ec; x.tc = et; x.busy = eb; x.name = nm;
        sb.push_back(x);
    endtask

    // Monitor: every cycle is an output presentation for this block.
    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                x = sb.pop_front();
                checks++;
                if (counter !== x.cnt || tc !== x.tc || busy !== x.busy) begin
                    errors++;
                    $display("FAIL %s: got counter=%0d tc=%0b busy=%0b, want counter=%0d tc=%0b busy=%0b",
                             x.name, counter, tc, busy, x.cnt, x.tc, x.busy);
                end
            end
        end
    end

    logic [3:0] ar_seq [3];

    initial begin : stimulus
        rst = 1'b0; load = 1'b0; load_val = 4'd0; en = 1'b0; auto_reload = 1'b0;
        ar_seq[0] = 4'd2; ar_seq[1] = 4'd1; ar_seq[2] = 4'd3;

        // 1. reset wins over load
        step(1, 1, 4'd9, 0, 0, 4'd0, 0, 0, "reset0");
        step(1, 1, 4'd9, 0, 0, 4'd0, 0, 0, "reset1");
        step(0, 0, 4'd0, 1, 0, 4'd0, 0, 0, "idle_en_ignored");

        // 2. one-shot from 5 (en on the load cycle is ignored)
        step(0, 1, 4'd5, 1, 0, 4'd5, 0, 1, "os_load5");
        step(0, 0, 4'd0, 1, 0, 4'd4, 0, 1, "os_4");
        step(0, 0, 4'd0, 1, 0, 4'd3, 0, 1, "os_3");
        step(0, 0, 4'd0, 1, 0, 4'd2, 0, 1, "os_2");
        step(0, 0, 4'd0, 1, 0, 4'd1, 0, 1, "os_1");
        step(0, 0, 4'd0, 1, 0, 4'd0, 1, 0, "os_tc");
        for (int i = 0; i < 10; i++)
            step(0, 0, 4'd0, 1, 0, 4'd0, 0, 0, "os_done_hold");

        // 3. auto-reload period 3
        step(0, 1, 4'd3, 1, 1, 4'd3, 0, 1, "ar_load3");
        for (int i = 0; i < 12; i++)
            step(0, 0, 4'd0, 1, 1, ar_seq[i%3], (i % 3 == 2), 1, "ar_cycle");

        // 4. enable gating
        step(0, 1, 4'd4, 0, 0, 4'd4, 0, 1, "eg_load4");
        step(0, 0, 4'd0, 1, 0, 4'd3, 0, 1, "eg_en1");
        step(0, 0, 4'd0, 0, 0, 4'd3, 0, 1, "eg_en0a");
        step(0, 0, 4'd0, 0, 0, 4'd3, 0, 1, "eg_en0b");
        step(0, 0, 4'd0, 1, 0, 4'd2, 0, 1, "eg_en1b");
        step(0, 0, 4'd0, 1, 0, 4'd1, 0, 1, "eg_en1c");
        step(0, 0, 4'd0, 0, 0, 4'd1, 0, 1, "eg_en0c");
        step(0, 0, 4'd0, 1, 0, 4'd0, 1, 0, "eg_tc");
        step(0, 0, 4'd0, 0, 0, 4'd0, 0, 0, "eg_tc_single");

        // 5a. load coincident with terminal event
        step(0, 1, 4'd3, 1, 0, 4'd3, 0, 1, "co_load3");
        step(0, 0, 4'd0, 1, 0, 4'd2, 0, 1, "co_2");
        step(0, 0, 4'd0, 1, 0, 4'd1, 0, 1, "co_1");
        step(0, 1, 4'd7, 1, 0, 4'd7, 0, 1, "co_load7_no_tc");
        step(0, 0, 4'd0, 1, 0, 4'd6, 0, 1, "co_6");

        // 5b. load of zero returns to idle
        step(0, 1, 4'd0, 1, 0, 4'd0, 0, 0, "z_load0");
        step(0, 0, 4'd0, 1, 0, 4'd0, 0, 0, "z_idle_en");

        // 5c. full range
        step(0, 1, 4'd15, 1, 0, 4'd15, 0, 1, "fr_load15");
        for (int i = 14; i >= 1; i--)
            step(0, 0, 4'd0, 1, 0, 4'(i), 0, 1, "fr_count");
        step(0, 0, 4'd0, 1, 0, 4'd0, 1, 0, "fr_tc");

        // auto-reload with period 1: tc every enabled cycle
        step(0, 1, 4'd1, 1, 1, 4'd1, 0, 1, "p1_load1");
        step(0, 0, 4'd0, 1, 1, 4'd1, 1, 1, "p1_tc_a");
        step(0, 0, 4'd0, 1, 1, 4'd1, 1, 1, "p1_tc_b");
        step(0, 0, 4'd0, 0, 1, 4'd1, 0, 1, "p1_hold");

        // auto_reload only matters at the terminal event
        step(0, 1, 4'd2, 1, 1, 4'd2, 0, 1, "ars_load2");
        step(0, 0, 4'd0, 1, 1, 4'd1, 0, 1, "ars_1");
        step(0, 0, 4'd0, 1, 0, 4'd0, 1, 0, "ars_oneshot_tc");

        // 6. reset mid-run
        step(0, 1, 4'd10, 0, 0, 4'd10, 0, 1, "rm_load10");
        step(0, 0, 4'd0, 1, 0, 4'd9, 0, 1, "rm_9");
        step(0, 0, 4'd0, 1, 0, 4'd8, 0, 1, "rm_8");
        step(0, 0, 4'd0, 1, 0, 4'd7, 0, 1, "rm_7");
        step(0, 0, 4'd0, 1, 0, 4'd6, 0, 1, "rm_6");
        step(1, 0, 4'd0, 1, 0, 4'd0, 0, 0, "rm_reset");
        for (int i = 0; i < 3; i++)
            step(0, 0, 4'd0, 1, 0, 4'd0, 0, 0, "rm_idle_en");
        step(0, 1, 4'd2, 0, 0, 4'd2, 0, 1, "rm_reload");

        @(negedge clk);
        load = 1'b0; en = 1'b0; rst = 1'b0;
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
Loadable down counter with terminal-count detection and optional auto-reload. It is the counterpart to the team's up counter. It loads a start value, decrements on each enabled clock, and flags when the count is exhausted. It is used as a countdown or periodic tick timer in sequential-circuit designs.

Parameters:
WIDTH, 4, bit width of the counter, the load value and the reload register.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
load  input  1  load strobe; captures load_val
load_val  input  WIDTH  start / reload value
en  input  1  count enable; decrement only when high
auto_reload  input  1  1 = periodic mode, 0 = one-shot mode
counter  output  WIDTH  current count (registered)
tc  output  1  terminal-count pulse, one cycle wide (registered)
busy  output  1  high while in RUN

Behaviour:
- Single clock domain. Reset is synchronous and active-high. All outputs are registered.
- Reset values: counter=0, tc=0, busy=0, reload register=0, state=IDLE. Reset wins over every other input. Reset mid-RUN aborts the count with no tc.
- FSM states: IDLE, RUN, DONE. busy=1 only in RUN.
- load priority: in any state, load=1 sets counter<=load_val and reload_reg<=load_val. It also sets tc<=0 and ignores en that cycle.
  - Next state is RUN if load_val!=0.
  - Next state is IDLE if load_val==0; counter=0 and no tc.
- IDLE: en is ignored, counter holds.
- RUN, en=0: counter holds, tc=0.
- RUN, en=1, counter>1: counter<=counter-1, tc=0.
- RUN, en=1, counter==1 (terminal event):
  - auto_reload=0: counter<=0, tc<=1, next state DONE.
  - auto_reload=1: counter<=reload_reg, tc<=1, stay RUN. The value 0 is never shown in this mode. Period is reload_reg enabled cycles, one tc per period.
- auto_reload is sampled at the terminal event only. Changing it mid-count has no other effect.
- DONE: counter holds 0, busy=0, tc=0 after its single pulse, en is ignored. Only load or rst leaves DONE.
- Underflow: none. The counter never decrements from 0 and never wraps to all-ones.
- tc is never high for two consecutive cycles unless reload_reg==1 with auto_reload=1 and en held high. In that case tc=1 every enabled cycle.
- Load coincident with a terminal event: load wins, no tc, count restarts from load_val.
- Latency: load or count effects are visible on counter the cycle after the sampling edge. tc rises on the same edge that counter shows 0 (one-shot) or the reload value (auto-reload).
- Full range: load_val = 2^WIDTH-1 (15 for WIDTH=4) counts down correctly. No arithmetic beyond WIDTH bits is required.

Test Plan:
1. Reset: rst=1 for 2 cycles with load=1, load_val=9 -> counter=0, tc=0, busy=0, state IDLE after release.
2. One-shot: load 5, then en=1 continuously -> counter 5,4,3,2,1,0. tc=1 only on the cycle counter first reads 0. busy falls with it. counter stays 0 for 10 more cycles.
3. Auto-reload: load 3, auto_reload=1, en=1 for 12 cycles -> counter 3,2,1,3,2,1,... tc pulses every 3rd cycle (4 pulses). busy stays 1. counter never shows 0.
4. Enable gating: load 4, en toggles 1,0,0,1,1,0,1 -> counter 3,3,3,2,1,1,0. tc is asserted once, at 0.
5. Simultaneous and edge events:
   - load 7 on the same cycle counter==1 with en=1 -> counter=7, no tc.
   - load_val=0 -> counter=0, busy=0, no tc.
   - load 15 -> 15 enabled cycles to tc.
6. Reset mid-operation: load 10, count to 6, assert rst for 1 cycle -> counter=0, busy=0, no tc. Later en=1 has no effect until the next load.
